// File: rtl/currctrl_sys_pulse_pio.sv
// currctrl_sys_pulse_pio
// Avalon-MM output PIO for the coil-driver reset/enable lines. Each output bit
// can be held at a level (DATA/SET/CLEAR) and/or driven by a timed one-shot
// pulse. Pulse completion is latched in a sticky DONE register that raises irq.
//
// Register map (word address):
//   0 DATA      RW  replace data_out
//   1 ACTIVE    RO  per-bit pulse running
//   2 PULSE_LEN RW  pulse length in clocks
//   3 DONE      RW  sticky pulse-done flags, write 1 to clear
//   4 SET       WO  data_out |= wd
//   5 CLEAR     WO  data_out &= ~wd, aborts pulses on those bits
//   6 PULSE     WO  start/retrigger pulses on wd bits
//   7 reserved
module currctrl_sys_pulse_pio #(
    parameter int               WIDTH       = 8,
    parameter int               CNT_W       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [CNT_W-1:0] PULSE_RST   = CNT_W'(100)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);

    localparam logic [2:0] A_DATA   = 3'd0;
    localparam logic [2:0] A_ACTIVE = 3'd1;
    localparam logic [2:0] A_LEN    = 3'd2;
    localparam logic [2:0] A_DONE   = 3'd3;
    localparam logic [2:0] A_SET    = 3'd4;
    localparam logic [2:0] A_CLEAR  = 3'd5;
    localparam logic [2:0] A_PULSE  = 3'd6;

    logic                        wr;
    logic                        wr_data, wr_len, wr_done, wr_set, wr_clr, wr_pulse;
    logic [WIDTH-1:0]            wd_bits;
    logic [CNT_W-1:0]            wd_len;
    logic                        unused_wd;

    logic [WIDTH-1:0]            data_out;
    logic [CNT_W-1:0]            pulse_len;
    logic [WIDTH-1:0][CNT_W-1:0] cnt;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_nxt;
    logic [WIDTH-1:0]            pulse_active;
    logic [WIDTH-1:0]            done;
    logic [WIDTH-1:0]            done_set;
    logic [WIDTH-1:0]            done_clr;

    assign wr       = chipselect & ~write_n;
    assign wr_data  = wr && (address == A_DATA);
    assign wr_len   = wr && (address == A_LEN);
    assign wr_done  = wr && (address == A_DONE);
    assign wr_set   = wr && (address == A_SET);
    assign wr_clr   = wr && (address == A_CLEAR);
    assign wr_pulse = wr && (address == A_PULSE);

    // Only the low WIDTH / CNT_W bits of the bus carry meaning.
    assign wd_bits   = writedata[WIDTH-1:0];
    assign wd_len    = writedata[CNT_W-1:0];
    assign unused_wd = ^writedata;

    assign done_clr  = wr_done ? wd_bits : '0;

    // Level output register: DATA replaces, SET/CLEAR modify individual bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out <= RESET_VALUE;
        end else if (wr_data) begin
            data_out <= wd_bits;
        end else if (wr_set) begin
            data_out <= data_out | wd_bits;
        end else if (wr_clr) begin
            data_out <= data_out & ~wd_bits;
        end
    end

    // Programmable pulse length; only sampled when a pulse is (re)triggered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pulse_len <= PULSE_RST;
        end else if (wr_len) begin
            pulse_len <= wd_len;
        end
    end

    // Per-bit pulse counters: abort beats reload beats count-down; a zero
    // length trigger leaves the counter alone. Done fires only on a natural
    // 1 -> 0 expiry, so a reload on the last cycle extends the same pulse.
    always_comb begin
        cnt_nxt  = cnt;
        done_set = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (wr_clr && wd_bits[i]) begin
                cnt_nxt[i] = '0;
            end else if (wr_pulse && wd_bits[i] && (pulse_len != '0)) begin
                cnt_nxt[i] = pulse_len;
            end else if (cnt[i] != '0) begin
                cnt_nxt[i] = cnt[i] - CNT_W'(1);
                if (cnt[i] == CNT_W'(1)) begin
                    done_set[i] = 1'b1;
                end
            end
        end
    end

    // Counter state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

    // Sticky done flags: a set on the same clock as a write-1-clear wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done <= '0;
        end else begin
            done <= (done & ~done_clr) | done_set;
        end
    end

    // Interrupt is a registered OR of the sticky flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq <= 1'b0;
        end else begin
            irq <= |done;
        end
    end

    // Active flags from counter state.
    always_comb begin
        pulse_active = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pulse_active[i] = (cnt[i] != '0);
        end
    end

    assign out_port = data_out | pulse_active;

    // Zero-latency read mux, zero-extended to the bus width.
    always_comb begin
        readdata = '0;
        case (address)
            A_DATA:   readdata[WIDTH-1:0] = data_out;
            A_ACTIVE: readdata[WIDTH-1:0] = pulse_active;
            A_LEN:    readdata[CNT_W-1:0] = pulse_len;
            A_DONE:   readdata[WIDTH-1:0] = done;
            default:  readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_currctrl_sys_pulse_pio.sv
// Testbench for currctrl_sys_pulse_pio: a table of level-access vectors plus
// hand-written sequences for pulse timing, retrigger, abort, reset and
// parameter extremes (8-bit, 1-bit and 32-bit instances).
module tb_currctrl_sys_pulse_pio;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        write_n;
    logic [31:0] writedata;
    logic        cs8, cs1, cs32;
    logic [31:0] rd8, rd1, rd32;
    logic [7:0]  out8;
    logic [0:0]  out1;
    logic [31:0] out32;
    logic        irq8, irq1, irq32;

    int n_pass  = 0;
    int n_total = 0;

    currctrl_sys_pulse_pio #(.WIDTH(8), .CNT_W(16), .RESET_VALUE(8'h05), .PULSE_RST(16'd100)) dut8 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs8), .write_n(write_n),
        .writedata(writedata), .readdata(rd8), .out_port(out8), .irq(irq8));

    currctrl_sys_pulse_pio #(.WIDTH(1), .CNT_W(1), .RESET_VALUE(1'b0), .PULSE_RST(1'b1)) dut1 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs1), .write_n(write_n),
        .writedata(writedata), .readdata(rd1), .out_port(out1), .irq(irq1));

    currctrl_sys_pulse_pio #(.WIDTH(32), .CNT_W(32), .RESET_VALUE(32'h0), .PULSE_RST(32'd100)) dut32 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs32), .write_n(write_n),
        .writedata(writedata), .readdata(rd32), .out_port(out32), .irq(irq32));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        do_wr;
        logic [2:0]  waddr;
        logic [31:0] wdata;
        logic [2:0]  raddr;
        logic [7:0]  exp_out;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input int sel, input logic [2:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write_n   = 1'b0;
        cs8       = (sel == 0);
        cs1       = (sel == 1);
        cs32      = (sel == 2);
        @(posedge clk);
        #1;
        write_n = 1'b1;
        cs8 = 1'b0; cs1 = 1'b0; cs32 = 1'b0;
    endtask

    task automatic bus_rd(input int sel, input logic [2:0] a, output logic [31:0] d);
        address = a;
        #1;
        case (sel)
            0:       d = rd8;
            1:       d = rd1;
            default: d = rd32;
        endcase
    endtask

    // Counts consecutive cycles (from now) where the output bit is high.
    task automatic measure(input int sel, input int bitn, output int n);
        logic b;
        n = 0;
        for (int k = 0; k < 200; k++) begin
            case (sel)
                0:       b = out8[bitn];
                1:       b = out1[0];
                default: b = out32[bitn];
            endcase
            if (!b) break;
            n++;
            step();
        end
    endtask

    logic [31:0] r;
    int          n;

    initial begin
        vecs[0] = '{1'b1, 3'd0, 32'h0000_00A0, 3'd0, 8'hA0, 32'h0000_00A0};
        vecs[1] = '{1'b1, 3'd4, 32'h0000_0003, 3'd0, 8'hA3, 32'h0000_00A3};
        vecs[2] = '{1'b1, 3'd5, 32'h0000_0020, 3'd0, 8'h83, 32'h0000_0083};
        vecs[3] = '{1'b1, 3'd1, 32'h0000_00FF, 3'd1, 8'h83, 32'h0000_0000};
        vecs[4] = '{1'b1, 3'd7, 32'h0000_00FF, 3'd7, 8'h83, 32'h0000_0000};
        vecs[5] = '{1'b1, 3'd2, 32'hABCD_0007, 3'd2, 8'h83, 32'h0000_0007};
        vecs[6] = '{1'b0, 3'd0, 32'h0000_0000, 3'd3, 8'h83, 32'h0000_0000};

        reset_n = 1'b0; address = 3'd0; write_n = 1'b1; writedata = '0;
        cs8 = 1'b0; cs1 = 1'b0; cs32 = 1'b0;
        #22;
        check("rst_out8", {24'h0, out8}, 32'h05);
        check("rst_irq8", {31'h0, irq8}, 32'h0);
        check("rst_out1", {31'h0, out1}, 32'h0);
        check("rst_out32", out32, 32'h0);
        bus_rd(0, 3'd2, r); check("rst_len8", r, 32'd100);
        @(posedge clk); #1; reset_n = 1'b1;

        // T1: reset asserted mid-pulse with a pending done/irq
        bus_wr(0, 3'd2, 32'd3);
        bus_wr(0, 3'd6, 32'h40);
        step(); step(); step(); step();
        check("t1_irq_pre", {31'h0, irq8}, 32'h1);
        bus_wr(0, 3'd6, 32'h02);
        step();
        check("t1_out_mid", {24'h0, out8}, 32'h07);
        #2 reset_n = 1'b0;
        #1;
        check("t1_out_async", {24'h0, out8}, 32'h05);
        check("t1_irq_async", {31'h0, irq8}, 32'h0);
        bus_rd(0, 3'd1, r); check("t1_active", r, 32'h0);
        bus_rd(0, 3'd2, r); check("t1_len", r, 32'd100);
        bus_rd(0, 3'd3, r); check("t1_done", r, 32'h0);
        @(posedge clk); #1; reset_n = 1'b1;

        // T2: level access vectors
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].do_wr) bus_wr(0, vecs[i].waddr, vecs[i].wdata);
            else step();
            check($sformatf("t2_out[%0d]", i), {24'h0, out8}, {24'h0, vecs[i].exp_out});
            bus_rd(0, vecs[i].raddr, r);
            check($sformatf("t2_rd[%0d]", i), r, vecs[i].exp_rd);
        end

        // T3: pulse timing, done and irq latency
        bus_wr(0, 3'd2, 32'd5);
        bus_wr(0, 3'd6, 32'h10);
        measure(0, 4, n);
        check("t3_len", n, 32'd5);
        bus_rd(0, 3'd3, r); check("t3_done", r, 32'h10);
        check("t3_irq_lag", {31'h0, irq8}, 32'h0);
        step();
        check("t3_irq", {31'h0, irq8}, 32'h1);

        // T4: retrigger extends one pulse
        bus_wr(0, 3'd0, 32'h0);
        bus_wr(0, 3'd3, 32'hFF);
        bus_wr(0, 3'd2, 32'd10);
        bus_wr(0, 3'd6, 32'h01);
        step(); step(); step();
        bus_rd(0, 3'd3, r); check("t4_done_early", r, 32'h0);
        bus_wr(0, 3'd6, 32'h01);
        measure(0, 0, n);
        check("t4_total", 4 + n, 32'd14);
        bus_rd(0, 3'd3, r); check("t4_done", r, 32'h01);
        bus_wr(0, 3'd3, 32'h01);
        // abort by CLEAR
        bus_wr(0, 3'd6, 32'h02);
        step(); step();
        check("t4_abort_mid", {24'h0, out8}, 32'h02);
        bus_wr(0, 3'd5, 32'h02);
        check("t4_abort_out", {24'h0, out8}, 32'h00);
        for (int k = 0; k < 12; k++) step();
        bus_rd(0, 3'd3, r); check("t4_abort_done", r, 32'h0);

        // T5: len changed mid-pulse, len=0 trigger is a no-op
        bus_wr(0, 3'd2, 32'd6);
        bus_wr(0, 3'd6, 32'h20);
        bus_wr(0, 3'd2, 32'd0);
        bus_wr(0, 3'd6, 32'hFF);
        check("t5_out_noop", {24'h0, out8}, 32'h20);
        bus_rd(0, 3'd1, r); check("t5_active", r, 32'h20);
        measure(0, 5, n);
        check("t5_remaining", n, 32'd4);
        bus_rd(0, 3'd3, r); check("t5_done", r, 32'h20);
        bus_wr(0, 3'd3, 32'hFF);
        bus_wr(0, 3'd6, 32'hFF);
        step();
        check("t5_len0_out", {24'h0, out8}, 32'h00);
        bus_rd(0, 3'd3, r); check("t5_len0_done", r, 32'h0);
        bus_rd(0, 3'd2, r); check("t5_len0", r, 32'h0);
        // W1C coinciding with done set
        bus_wr(0, 3'd2, 32'd3);
        bus_wr(0, 3'd6, 32'h04);
        step(); step();
        bus_wr(0, 3'd3, 32'h04);
        bus_rd(0, 3'd3, r); check("t5_w1c_race", r, 32'h04);
        bus_wr(0, 3'd3, 32'h04);
        bus_rd(0, 3'd3, r); check("t5_w1c", r, 32'h0);
        // pulse on a bit already held high
        bus_wr(0, 3'd0, 32'h80);
        bus_wr(0, 3'd6, 32'h80);
        check("t5_hi_out", {24'h0, out8}, 32'h80);
        step(); step(); step();
        check("t5_hi_out_end", {24'h0, out8}, 32'h80);
        bus_rd(0, 3'd3, r); check("t5_hi_done", r, 32'h80);
        bus_rd(0, 3'd1, r); check("t5_hi_active", r, 32'h0);
        bus_wr(0, 3'd7, 32'hFF);
        bus_rd(0, 3'd7, r); check("t5_addr7", r, 32'h0);
        check("t5_addr7_out", {24'h0, out8}, 32'h80);

        // T6: WIDTH=1, CNT_W=1
        bus_wr(1, 3'd2, 32'hFFFF_FFFF);
        bus_rd(1, 3'd2, r); check("t6a_len", r, 32'h1);
        bus_wr(1, 3'd6, 32'h1);
        measure(1, 0, n);
        check("t6a_pulse", n, 32'd1);
        bus_rd(1, 3'd3, r); check("t6a_done", r, 32'h1);
        step();
        check("t6a_irq", {31'h0, irq1}, 32'h1);

        // T6: WIDTH=32, CNT_W=32
        bus_wr(2, 3'd2, 32'd5);
        bus_wr(2, 3'd6, 32'h8000_0000);
        measure(2, 31, n);
        check("t6b_pulse", n, 32'd5);
        bus_rd(2, 3'd3, r); check("t6b_done", r, 32'h8000_0000);
        bus_wr(2, 3'd2, 32'hFFFF_FFFF);
        bus_rd(2, 3'd2, r); check("t6b_len", r, 32'hFFFF_FFFF);
        bus_wr(2, 3'd6, 32'h1);
        for (int k = 0; k < 4; k++) step();
        bus_rd(2, 3'd1, r); check("t6b_active", r, 32'h1);
        check("t6b_out", out32, 32'h1);
        bus_wr(2, 3'd5, 32'h1);
        bus_rd(2, 3'd1, r); check("t6b_abort", r, 32'h0);
        bus_rd(2, 3'd3, r); check("t6b_abort_done", r, 32'h8000_0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
